// File: rtl/game_pkg.sv
// Shared types and default match parameters for the penalty-shootout game.
package game_pkg;

    typedef enum logic [2:0] {
        START   = 3'd0,
        KEEPER  = 3'd1,
        SHOOTER = 3'd2,
        WINNER  = 3'd3,
        LOOSER  = 3'd4
    } g_state;

    typedef enum logic {
        SOLO  = 1'b0,
        MULTI = 1'b1
    } g_mode;

    localparam int DEF_ROUNDS         = 10;
    localparam int DEF_WIN_SCORE      = 5;
    localparam int DEF_RESULT_FRAMES  = 120;
    localparam int DEF_TIMEOUT_FRAMES = 600;
    localparam int FRAME_W            = 10;

    function automatic logic [2:0] score_inc(input logic [2:0] s);
        return (s == 3'd7) ? s : s + 3'd1;
    endfunction

    // Even rounds are shot by the player, odd rounds are defended.
    function automatic g_state role_of(input logic [3:0] rc);
        return rc[0] ? KEEPER : SHOOTER;
    endfunction

endpackage

// File: rtl/control_if.sv
// Control bundle driven by the game sequencer and read by screen/draw logic.
import game_pkg::*;

interface control_if;
    logic         is_scored;
    logic [3:0]   round_counter;
    logic [2:0]   score;
    g_mode        game_mode;
    g_state       game_state;

    modport out (
        output is_scored,
        output round_counter,
        output score,
        output game_mode,
        output game_state
    );

    modport in (
        input is_scored,
        input round_counter,
        input score,
        input game_mode,
        input game_state
    );
endinterface

// File: rtl/frame_timer.sv
// Saturating frame counter with synchronous clear and a tick-qualified compare hit.
module frame_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    // Hit fires on the tick that would take the count past the limit.
    assign hit = tick && (count == limit);

endmodule

// File: rtl/game_controller.sv
// Penalty-shootout sequencer: start screen, alternating rounds, result hold, final screen.
import game_pkg::*;

module game_controller #(
    parameter int ROUNDS         = game_pkg::DEF_ROUNDS,
    parameter int WIN_SCORE      = game_pkg::DEF_WIN_SCORE,
    parameter int RESULT_FRAMES  = game_pkg::DEF_RESULT_FRAMES,
    parameter int TIMEOUT_FRAMES = game_pkg::DEF_TIMEOUT_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       mode_sel,
    input  logic       shot_valid,
    input  logic       shot_goal,
    control_if.out     out_control
);

    // state  | meaning
    // IDLE   | start screen, waiting for btn_start
    // PLAY   | round in progress, waiting for shot or timeout
    // RESULT | round outcome held for RESULT_FRAMES frames
    // DONE   | winner/looser screen, waiting for restart
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        RESULT = 2'd2,
        DONE   = 2'd3
    } fsm_t;

    localparam logic [FRAME_W-1:0] TO_LIM   = FRAME_W'(TIMEOUT_FRAMES - 1);
    localparam logic [FRAME_W-1:0] RES_LIM  = FRAME_W'(RESULT_FRAMES - 1);
    localparam logic [3:0]         LAST_RND = 4'(ROUNDS - 1);

    fsm_t         fsm_q, fsm_d;
    g_state       state_q, state_d;
    g_mode        mode_q, mode_d;
    logic [3:0]   round_q, round_d;
    logic [2:0]   score_q, score_d;
    logic         scored_q, scored_d;

    logic               timer_clr;
    logic               timer_hit;
    logic [FRAME_W-1:0] timer_limit;
    logic               keeper_round;
    logic [3:0]         round_next;

    assign keeper_round = round_q[0];
    assign round_next   = round_q + 4'd1;

    frame_timer #(.W(FRAME_W)) u_frame_timer (
        .clk   (clk),
        .rst   (rst),
        .tick  (frame_tick),
        .clr   (timer_clr),
        .limit (timer_limit),
        .hit   (timer_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= IDLE;
            state_q  <= START;
            mode_q   <= MULTI;
            round_q  <= 4'd0;
            score_q  <= 3'd0;
            scored_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            mode_q   <= mode_d;
            round_q  <= round_d;
            score_q  <= score_d;
            scored_q <= scored_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        mode_d      = mode_q;
        round_d     = round_q;
        score_d     = score_q;
        scored_d    = scored_q;
        timer_clr   = 1'b0;
        timer_limit = TO_LIM;

        case (fsm_q)
            IDLE: begin
                timer_clr = 1'b1;
                if (btn_start) begin
                    mode_d   = g_mode'(mode_sel);
                    round_d  = 4'd0;
                    score_d  = 3'd0;
                    scored_d = 1'b0;
                    state_d  = role_of(4'd0);
                    fsm_d    = PLAY;
                end
            end

            PLAY: begin
                timer_limit = TO_LIM;
                if (shot_valid) begin
                    scored_d  = shot_goal;
                    if (keeper_round ? !shot_goal : shot_goal) begin
                        score_d = score_inc(score_q);
                    end
                    timer_clr = 1'b1;
                    fsm_d     = RESULT;
                end else if (timer_hit) begin
                    // No shot in time: a miss for the shooter, a save for the keeper.
                    scored_d  = 1'b0;
                    if (keeper_round) begin
                        score_d = score_inc(score_q);
                    end
                    timer_clr = 1'b1;
                    fsm_d     = RESULT;
                end
            end

            RESULT: begin
                timer_limit = RES_LIM;
                if (timer_hit) begin
                    scored_d  = 1'b0;
                    timer_clr = 1'b1;
                    if (round_q == LAST_RND) begin
                        state_d = (int'(score_q) >= WIN_SCORE) ? WINNER : LOOSER;
                        fsm_d   = DONE;
                    end else begin
                        round_d = round_next;
                        state_d = role_of(round_next);
                        fsm_d   = PLAY;
                    end
                end
            end

            DONE: begin
                timer_clr = 1'b1;
                if (btn_start) begin
                    state_d  = START;
                    round_d  = 4'd0;
                    score_d  = 3'd0;
                    scored_d = 1'b0;
                    fsm_d    = IDLE;
                end
            end

            default: begin
                fsm_d     = IDLE;
                timer_clr = 1'b1;
            end
        endcase
    end

    assign out_control.game_state    = state_q;
    assign out_control.game_mode     = mode_q;
    assign out_control.round_counter = round_q;
    assign out_control.score         = score_q;
    assign out_control.is_scored     = scored_q;

endmodule

// File: tb/tb_game_controller.sv
// Table-driven and model-driven checks of the game sequencer with an expected-output queue.
module tb_game_controller;

    typedef struct {
        string      name;
        int         pre;
        logic       r;
        logic       bs;
        logic       ms;
        logic       sv;
        logic       sg;
        logic       ft;
        logic [2:0] st;
        logic       md;
        logic [3:0] rc;
        logic [2:0] sc;
        logic       is;
    } vec_t;

    localparam logic [2:0] S_START = 3'd0, S_KEEP = 3'd1, S_SHOOT = 3'd2,
                           S_WIN = 3'd3, S_LOOSE = 3'd4;

    logic clk = 1'b0;
    logic rst, frame_tick, btn_start, mode_sel, shot_valid, shot_goal;

    int vectors = 0;
    int miscompares = 0;

    vec_t exp_q[$];
    vec_t tbl[$];

    logic [3:0] m_round;
    logic [2:0] m_score;
    logic       m_mode;

    control_if ctl ();

    game_controller dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .btn_start   (btn_start),
        .mode_sel    (mode_sel),
        .shot_valid  (shot_valid),
        .shot_goal   (shot_goal),
        .out_control (ctl)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input int pre,
                                input logic r, input logic bs, input logic ms,
                                input logic sv, input logic sg, input logic ft,
                                input logic [2:0] st, input logic md,
                                input logic [3:0] rc, input logic [2:0] sc,
                                input logic is);
        vec_t v;
        v.name = name; v.pre = pre; v.r = r; v.bs = bs; v.ms = ms;
        v.sv = sv; v.sg = sg; v.ft = ft;
        v.st = st; v.md = md; v.rc = rc; v.sc = sc; v.is = is;
        return v;
    endfunction

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(posedge clk);
            #1;
        end
        frame_tick = 1'b0;
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: no expected entry for DUT output");
        end else begin
            e = exp_q.pop_front();
            vectors++;
            if (ctl.game_state !== e.st || ctl.game_mode !== e.md ||
                ctl.round_counter !== e.rc || ctl.score !== e.sc ||
                ctl.is_scored !== e.is) begin
                miscompares++;
                $display("FAIL %s: got st=%0d md=%0d rc=%0d sc=%0d is=%0d, want st=%0d md=%0d rc=%0d sc=%0d is=%0d",
                         e.name, ctl.game_state, ctl.game_mode, ctl.round_counter,
                         ctl.score, ctl.is_scored, e.st, e.md, e.rc, e.sc, e.is);
            end
        end
    endtask

    task automatic apply(input vec_t v);
        run_ticks(v.pre);
        rst        = v.r;
        btn_start  = v.bs;
        mode_sel   = v.ms;
        shot_valid = v.sv;
        shot_goal  = v.sg;
        frame_tick = v.ft;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        rst = 1'b0; btn_start = 1'b0; mode_sel = 1'b0;
        shot_valid = 1'b0; shot_goal = 1'b0; frame_tick = 1'b0;
        check_out();
    endtask

    // Reference scoring: shooter earns a goal, keeper earns a non-goal; saturating at 7.
    task automatic model_shot(input logic goal);
        logic keeper;
        logic point;
        keeper = m_round[0];
        point  = keeper ? !goal : goal;
        if (point && m_score != 3'd7) m_score = m_score + 3'd1;
        apply(mk("model_shot", 0, 0, 0, 0, 1, goal, 0,
                 keeper ? S_KEEP : S_SHOOT, m_mode, m_round, m_score, goal));
    endtask

    task automatic model_hold();
        logic [2:0] st;
        if (m_round == 4'd9) begin
            st = (m_score >= 3'd5) ? S_WIN : S_LOOSE;
        end else begin
            m_round = m_round + 4'd1;
            st = m_round[0] ? S_KEEP : S_SHOOT;
        end
        apply(mk("model_hold_end", 119, 0, 0, 0, 0, 0, 1, st, m_mode, m_round, m_score, 1'b0));
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; btn_start = 1'b0;
        mode_sel = 1'b0; shot_valid = 1'b0; shot_goal = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (1000) @(posedge clk);
        #1;

        //            name               pre  r bs ms sv sg ft  st       md rc  sc is
        tbl.push_back(mk("idle_reset",     0, 0, 0, 0, 0, 0, 0, S_START, 1, 0, 0, 0));
        tbl.push_back(mk("start_solo",     0, 0, 1, 0, 0, 0, 0, S_SHOOT, 0, 0, 0, 0));
        tbl.push_back(mk("shot_goal_r0",   0, 0, 0, 0, 1, 1, 0, S_SHOOT, 0, 0, 1, 1));
        tbl.push_back(mk("hold_tick119", 118, 0, 0, 0, 0, 0, 1, S_SHOOT, 0, 0, 1, 1));
        tbl.push_back(mk("hold_tick120",   0, 0, 0, 0, 0, 0, 1, S_KEEP,  0, 1, 1, 0));
        tbl.push_back(mk("keeper_save",    0, 0, 0, 0, 1, 0, 0, S_KEEP,  0, 1, 2, 0));
        tbl.push_back(mk("result_shot_ign",0, 0, 0, 0, 1, 1, 0, S_KEEP,  0, 1, 2, 0));
        tbl.push_back(mk("result_btn_ign", 0, 0, 1, 1, 0, 0, 0, S_KEEP,  0, 1, 2, 0));
        tbl.push_back(mk("r2_enter",     119, 0, 0, 0, 0, 0, 1, S_SHOOT, 0, 2, 2, 0));
        tbl.push_back(mk("play_btn_ign",   0, 0, 1, 1, 0, 0, 0, S_SHOOT, 0, 2, 2, 0));
        tbl.push_back(mk("timeout_599",  598, 0, 0, 0, 0, 0, 1, S_SHOOT, 0, 2, 2, 0));
        tbl.push_back(mk("timeout_600",    0, 0, 0, 0, 0, 0, 1, S_SHOOT, 0, 2, 2, 0));
        tbl.push_back(mk("timeout_shot_ign",0,0, 0, 0, 1, 1, 0, S_SHOOT, 0, 2, 2, 0));
        tbl.push_back(mk("r3_enter",     119, 0, 0, 0, 0, 0, 1, S_KEEP,  0, 3, 2, 0));
        tbl.push_back(mk("keeper_timeout",599,0, 0, 0, 0, 0, 1, S_KEEP,  0, 3, 3, 0));
        tbl.push_back(mk("r4_enter",     119, 0, 0, 0, 0, 0, 1, S_SHOOT, 0, 4, 3, 0));
        tbl.push_back(mk("shot_and_tick",  0, 0, 0, 0, 1, 1, 1, S_SHOOT, 0, 4, 4, 1));
        tbl.push_back(mk("hold_from_zero",118,0, 0, 0, 0, 0, 1, S_SHOOT, 0, 4, 4, 1));
        tbl.push_back(mk("r5_enter",       0, 0, 0, 0, 0, 0, 1, S_KEEP,  0, 5, 4, 0));
        tbl.push_back(mk("keeper_concede", 0, 0, 0, 0, 1, 1, 0, S_KEEP,  0, 5, 4, 1));
        tbl.push_back(mk("r6_enter",     119, 0, 0, 0, 0, 0, 1, S_SHOOT, 0, 6, 4, 0));
        tbl.push_back(mk("shooter_miss",   0, 0, 0, 0, 1, 0, 0, S_SHOOT, 0, 6, 4, 0));
        tbl.push_back(mk("r7_enter",     119, 0, 0, 0, 0, 0, 1, S_KEEP,  0, 7, 4, 0));
        tbl.push_back(mk("keeper_save2",   0, 0, 0, 0, 1, 0, 0, S_KEEP,  0, 7, 5, 0));
        tbl.push_back(mk("r8_enter",     119, 0, 0, 0, 0, 0, 1, S_SHOOT, 0, 8, 5, 0));
        tbl.push_back(mk("shooter_miss2",  0, 0, 0, 0, 1, 0, 0, S_SHOOT, 0, 8, 5, 0));
        tbl.push_back(mk("r9_enter",     119, 0, 0, 0, 0, 0, 1, S_KEEP,  0, 9, 5, 0));
        tbl.push_back(mk("keeper_concede2",0, 0, 0, 0, 1, 1, 0, S_KEEP,  0, 9, 5, 1));
        tbl.push_back(mk("last_hold_119",118, 0, 0, 0, 0, 0, 1, S_KEEP,  0, 9, 5, 1));
        tbl.push_back(mk("done_winner",    0, 0, 0, 0, 0, 0, 1, S_WIN,   0, 9, 5, 0));
        tbl.push_back(mk("done_shot_ign",  0, 0, 0, 0, 1, 1, 0, S_WIN,   0, 9, 5, 0));
        tbl.push_back(mk("done_tick_hold", 0, 0, 0, 0, 0, 0, 1, S_WIN,   0, 9, 5, 0));
        tbl.push_back(mk("restart_keep_md",0, 0, 1, 1, 0, 0, 0, S_START, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Second match in MULTI: four points in total ends in LOOSER.
        apply(mk("start_multi", 0, 0, 1, 1, 0, 0, 0, S_SHOOT, 1, 0, 0, 0));
        m_round = 4'd0; m_score = 3'd0; m_mode = 1'b1;
        for (int r = 0; r < 10; r++) begin
            model_shot((r == 8) ? 1'b0 : 1'b1);
            model_hold();
        end
        apply(mk("looser_restart", 0, 0, 1, 0, 0, 0, 0, S_START, 1, 0, 0, 0));

        // Third match: every round scores, so the score pins at 7.
        apply(mk("start_sat", 0, 0, 1, 0, 0, 0, 0, S_SHOOT, 0, 0, 0, 0));
        m_round = 4'd0; m_score = 3'd0; m_mode = 1'b0;
        for (int r = 0; r < 8; r++) begin
            model_shot(m_round[0] ? 1'b0 : 1'b1);
            model_hold();
        end
        model_shot(1'b1);
        apply(mk("sat_still_7",   10, 0, 0, 0, 0, 0, 1, S_SHOOT, 0, 8, 7, 1));
        apply(mk("rst_mid_result", 0, 1, 0, 0, 0, 0, 1, S_START, 1, 0, 0, 0));
        apply(mk("after_rst_idle", 0, 0, 0, 0, 1, 1, 1, S_START, 1, 0, 0, 0));
        apply(mk("after_rst_start",0, 0, 1, 0, 0, 0, 0, S_SHOOT, 0, 0, 0, 0));
        apply(mk("after_rst_to599",599,0, 0, 0, 0, 0, 0, S_SHOOT, 0, 0, 0, 0));
        apply(mk("after_rst_shot", 0, 0, 0, 0, 1, 1, 0, S_SHOOT, 0, 0, 1, 1));

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: %0d entries, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
